// File: rtl/uart_pkg.sv
// Shared UART constants and the FSM state encoding (also used by the transmitter).
package uart_pkg;

    localparam int unsigned CLK_HZ       = 12_000_000;
    localparam int unsigned BAUD_DEFAULT = 115_200;
    localparam int unsigned DATA_W       = 8;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // 12 MHz / 115200 truncates to 104 cycles per bit
    localparam int unsigned CLKS_PER_BIT_DEFAULT = clks_per_bit(CLK_HZ, BAUD_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: extra-MSB pointers, registered head byte and status flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         drop_c_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  head_q, head_d;
    logic          empty_q, full_q;
    logic          do_push_c, do_pop_c;

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
    always_comb begin
        do_pop_c  = pop_i & ~empty_q;
        do_push_c = push_i & (~full_q | do_pop_c);
        drop_c_o  = push_i & full_q & ~do_pop_c;
        wr_ptr_d  = wr_ptr_q + PW'(do_push_c);
        rd_ptr_d  = rd_ptr_q + PW'(do_pop_c);
        head_d    = head_q;
        if (rd_ptr_d != wr_ptr_d) begin
            // bypass when the next head is the entry being written this cycle
            if (do_push_c && (rd_ptr_d == wr_ptr_q)) begin
                head_d = din_i;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            empty_q  <= (rd_ptr_d == wr_ptr_d);
            full_q   <= (rd_ptr_d[PW-1] != wr_ptr_d[PW-1]) &&
                        (rd_ptr_d[AW-1:0] == wr_ptr_d[AW-1:0]);
        end
    end

    assign head_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: pin synchroniser, mid-bit sampling FSM, byte FIFO, sticky errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DEPTH        = 4
) (
    input  logic              clk12MHz,
    input  logic              resetn,
    input  logic              rx,
    output logic [DATA_W-1:0] recvData,
    output logic              valid,
    input  logic              recvAck,
    output logic              overrun,
    output logic              frameErr,
    input  logic              clearErr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_meta_q, rx_s_q, rx_d_q;
    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              push_q, push_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              ferr_set_c;
    logic              fifo_empty, fifo_full, fifo_drop_c;
    logic [DATA_W-1:0] fifo_head;
    logic              unused_fifo_full;

    // Two-stage synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        push_d     = 1'b0;
        ferr_set_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // only a fresh falling edge starts a frame, so a held-low line stays idle
                if (rx_d_q && !rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        cnt_d     = CNT_FULL;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d   = {rx_s_q, shreg_q[DATA_W-1:1]};
                    cnt_d     = CNT_FULL;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    push_d     = rx_s_q;
                    ferr_set_c = ~rx_s_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error flags are sticky; a new error in the same cycle as clearErr wins.
    always_comb begin
        frame_err_d = ferr_set_c | (frame_err_q & ~clearErr);
        overrun_d   = fifo_drop_c | (overrun_q & ~clearErr);
    end

    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk      (clk12MHz),
        .rst_n    (resetn),
        .push_i   (push_q),
        .din_i    (shreg_q),
        .pop_i    (recvAck),
        .head_o   (fifo_head),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full),
        .drop_c_o (fifo_drop_c)
    );

    // overrun comes from the FIFO drop strobe; full is not needed at this level
    assign unused_fifo_full = fifo_full;

    assign recvData = fifo_head;
    assign valid    = ~fifo_empty;
    assign overrun  = overrun_q;
    assign frameErr = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a queue model.
module tb_uart_rx;

    localparam int unsigned CPB   = 104;
    localparam int unsigned DEPTH = 4;
    // offset inside the stop bit where the stop sample edge falls (start drive + 3 + CPB/2 + 9*CPB)
    localparam int unsigned STOP_C = CPB / 2 + 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       recvAck = 1'b0;
    logic       clearErr = 1'b0;
    logic [7:0] recvData;
    logic       valid;
    logic       overrun;
    logic       frameErr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    logic [7:0] m_last = 8'h00;
    logic       m_over = 1'b0;
    logic       m_ferr = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk12MHz (clk),
        .resetn   (resetn),
        .rx       (rx),
        .recvData (recvData),
        .valid    (valid),
        .recvAck  (recvAck),
        .overrun  (overrun),
        .frameErr (frameErr),
        .clearErr (clearErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_head();
        return (mq.size() != 0) ? mq[0] : m_last;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; checks valid just before the push edge and the whole status just after it.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_push, input string tag);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < int'(CPB); c++) begin
                @(posedge clk);
                #1;
                if (i == 9 && c == int'(STOP_C)) begin
                    n_tests++;
                    if (valid !== (mq.size() != 0)) begin
                        n_fail++;
                        $display("FAIL %s pre-push valid: got %0b expected %0b", tag, valid, mq.size() != 0);
                    end
                    if (ack_push) recvAck = 1'b1;
                end
                if (i == 9 && c == int'(STOP_C) + 1) begin
                    recvAck = 1'b0;
                    if (ack_push && mq.size() != 0) m_last = mq.pop_front();
                    if (stop_ok) begin
                        if (mq.size() < DEPTH) mq.push_back(b);
                        else m_over = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    n_tests++;
                    if (valid !== (mq.size() != 0)) begin
                        n_fail++;
                        $display("FAIL %s push valid: got %0b expected %0b", tag, valid, mq.size() != 0);
                    end
                    n_tests++;
                    if (recvData !== exp_head()) begin
                        n_fail++;
                        $display("FAIL %s push recvData: got %02h expected %02h", tag, recvData, exp_head());
                    end
                    n_tests++;
                    if (overrun !== m_over || frameErr !== m_ferr) begin
                        n_fail++;
                        $display("FAIL %s push flags: got ovr=%0b ferr=%0b expected ovr=%0b ferr=%0b",
                                 tag, overrun, frameErr, m_over, m_ferr);
                    end
                end
            end
        end
    endtask

    task automatic pop_one(input string tag);
        n_tests++;
        if (valid !== (mq.size() != 0) || recvData !== exp_head()) begin
            n_fail++;
            $display("FAIL %s before pop: got valid=%0b data=%02h expected valid=%0b data=%02h",
                     tag, valid, recvData, mq.size() != 0, exp_head());
        end
        recvAck = 1'b1;
        @(posedge clk);
        #1;
        recvAck = 1'b0;
        if (mq.size() != 0) m_last = mq.pop_front();
        n_tests++;
        if (valid !== (mq.size() != 0) || recvData !== exp_head()) begin
            n_fail++;
            $display("FAIL %s after pop: got valid=%0b data=%02h expected valid=%0b data=%02h",
                     tag, valid, recvData, mq.size() != 0, exp_head());
        end
    endtask

    task automatic clear_errors(input string tag);
        clearErr = 1'b1;
        @(posedge clk);
        #1;
        clearErr = 1'b0;
        m_over = 1'b0;
        m_ferr = 1'b0;
        n_tests++;
        if (overrun !== 1'b0 || frameErr !== 1'b0) begin
            n_fail++;
            $display("FAIL %s clearErr: got ovr=%0b ferr=%0b expected 0 0", tag, overrun, frameErr);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wait_cycles(3);
        n_tests++;
        if (valid !== 1'b0 || recvData !== 8'h00 || overrun !== 1'b0 || frameErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%0b data=%02h ovr=%0b ferr=%0b expected 0 00 0 0",
                     valid, recvData, overrun, frameErr);
        end
        resetn = 1'b1;
        wait_cycles(10);
        n_tests++;
        if (valid !== 1'b0 || recvData !== 8'h00 || overrun !== 1'b0 || frameErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%0b data=%02h ovr=%0b ferr=%0b expected 0 00 0 0",
                     valid, recvData, overrun, frameErr);
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 1'b0, "basic_a5");
        wait_cycles(20);
        pop_one("basic_pop");
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(200);
        n_tests++;
        if (valid !== 1'b0 || overrun !== 1'b0 || frameErr !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got valid=%0b ovr=%0b ferr=%0b expected 0 0 0", valid, overrun, frameErr);
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, "frame_3c");
        wait_cycles(3000);
        n_tests++;
        if (valid !== 1'b0 || frameErr !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL break_hold: got valid=%0b ferr=%0b ovr=%0b expected 0 1 0", valid, frameErr, overrun);
        end
        rx = 1'b1;
        wait_cycles(10);
        clear_errors("framing");
        wait_cycles(200);
        n_tests++;
        if (valid !== 1'b0 || frameErr !== 1'b0) begin
            n_fail++;
            $display("FAIL after_break: got valid=%0b ferr=%0b expected 0 0", valid, frameErr);
        end
    endtask

    task automatic test_overrun();
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0, "ovr_fill");
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %0b expected 1", overrun);
        end
        for (int k = 0; k < 4; k++) pop_one("ovr_drain");
        n_tests++;
        if (valid !== 1'b0 || recvData !== 8'h04) begin
            n_fail++;
            $display("FAIL ovr_empty: got valid=%0b data=%02h expected 0 04", valid, recvData);
        end
        clear_errors("overrun");
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0, "b2b_fill");
        send_frame(8'h06, 1'b1, 1'b1, "b2b_full_pop_push");
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_push overrun: got %0b expected 0", overrun);
        end
        for (int k = 0; k < 4; k++) pop_one("b2b_drain");
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h77, 1'b1, 1'b0, "pre_reset_77");
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(4 * CPB + CPB / 2);
        resetn = 1'b0;
        mq.delete();
        m_last = 8'h00;
        m_over = 1'b0;
        m_ferr = 1'b0;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(1200);
        n_tests++;
        if (valid !== 1'b0 || recvData !== 8'h00 || overrun !== 1'b0 || frameErr !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got valid=%0b data=%02h ovr=%0b ferr=%0b expected 0 00 0 0",
                     valid, recvData, overrun, frameErr);
        end
        send_frame(8'h5A, 1'b1, 1'b0, "post_reset_5a");
        pop_one("post_reset_pop");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] b;
            bit ok;
            bit ack;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            ack = 1'($urandom_range(0, 1));
            send_frame(b, ok, ack, "rand_frame");
            rx = 1'b1;
            wait_cycles(int'($urandom_range(4, 40)));
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) pop_one("rand_pop");
            if ($urandom_range(0, 3) == 0) clear_errors("rand");
        end
        while (mq.size() != 0) pop_one("rand_drain");
        n_tests++;
        if (valid !== 1'b0 || overrun !== m_over || frameErr !== m_ferr) begin
            n_fail++;
            $display("FAIL rand_end: got valid=%0b ovr=%0b ferr=%0b expected 0 %0b %0b",
                     valid, overrun, frameErr, m_over, m_ferr);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the SoC's 8N1 UART, the counterpart of the existing transmitter. It sits on the `clk12MHz` domain beside `uart` and is polled by the CPU through the memory-mapped I/O decoder. It synchronises the raw RX pin and samples each bit at its midpoint, then pushes received bytes into a small FIFO. Overrun and framing errors are reported as sticky flags.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per bit (12 MHz / 115200 baud); must be ≥ 4.
- `DEPTH`, 4, FIFO depth in bytes; must be a power of two, ≥ 2.
- `clk12MHz`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial line, asynchronous to the clock, idles high.
- `recvData`  out  8  byte at the FIFO head; holds the last head value when empty, `8'h00` after reset.
- `valid`  out  1  FIFO not empty; reset 0.
- `recvAck`  in  1  single-cycle pop of the head byte; ignored when `valid`=0.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full; reset 0.
- `frameErr`  out  1  sticky: a stop bit was sampled low; reset 0.
- `clearErr`  in  1  clears `overrun` and `frameErr`.

## Operation
- Input path: 2-FF synchroniser, with the second stage reset to 1, giving `rx_s`. A registered copy `rx_d` is kept for edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_d`=1 && `rx_s`=0, go to START and load `cnt` = `CLKS_PER_BIT/2 - 1`.
  - START: when `cnt` reaches 0, sample `rx_s`.
    - If it is 0, go to DATA with `cnt` = `CLKS_PER_BIT-1` and `bitIdx` = 0.
    - If it is 1, the start was a glitch; go to IDLE with no side effects.
  - DATA: each time `cnt` reaches 0, shift `rx_s` into `shreg` LSB-first and reload `cnt`. After `bitIdx` = 7 is sampled, go to STOP with `cnt` = `CLKS_PER_BIT-1`.
  - STOP: when `cnt` reaches 0, sample `rx_s`.
    - If it is 1, push `shreg` into the FIFO.
    - If it is 0, set `frameErr` and discard the byte.
    - In both cases go to IDLE.
- After a framing error, IDLE needs a fresh falling edge. A held-low break therefore produces exactly one `frameErr` and no further frames.
- FIFO behaviour:
  - Read and write pointers are `$clog2(DEPTH)+1` bits wide, with wrap-around by natural overflow.
  - Full means the pointer MSBs differ and the low bits are equal; empty means the pointers are equal.
  - Push while full with no pop in the same cycle: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both happen and `overrun` stays unchanged.
  - Push and pop in the same cycle while empty: only the push happens, because the pop is ignored.
- Error flags: `clearErr` in the same cycle as a new error event leaves the flag set (set wins).
- Reset mid-frame: every state element returns to its reset value at once, the FIFO empties, and the FSM goes to IDLE. The remainder of the interrupted frame must not produce a push, because the FSM waits for a falling edge.

## Timing
- `rx` pin to `rx_s`: 2 cycles.
- Start-edge detection to start-bit sample: `CLKS_PER_BIT/2` cycles, which is 52 for the default.
- Sampling then continues every `CLKS_PER_BIT` cycles: 8 data samples, then the stop sample.
- Stop sample cycle N → `valid`=1 and `recvData` updated at cycle N+1 (registered push).
- `recvAck` at cycle M → the next head byte (or `valid`=0) appears at M+1. `recvData` is driven from a registered head, not a combinational RAM read.
- Sustained back-to-back frames at full line rate: every frame is received, provided the consumer pops at least once per 10·`CLKS_PER_BIT` cycles.

## Structure
- Shared package `uart_pkg`:
  - the 12 MHz clock constant and the default baud rate;
  - the `CLKS_PER_BIT` derivation;
  - the FSM state encoding, shared with the future transmitter refactor.
- Sub-module `uart_rx_fifo`: a synchronous FIFO with `DEPTH` parameter and push, pop, full, empty, head and drop (overrun) outputs. The FSM and synchroniser stay in `uart_rx`.
- Memory-map integration (status word = {`frameErr`, `overrun`, `valid`}, with the data read generating `recvAck`) belongs in `top`, not in this block.

## Test plan
- Reset, then send byte 8'hA5 at 104 cycles per bit: `valid` rises exactly 1 cycle after the stop sample, `recvData`=8'hA5, both flags stay 0, and `recvAck` clears `valid`.
- Glitch: drive `rx` low for 20 cycles, then high: the FSM returns to IDLE, `valid` stays 0, and no flag is set.
- Send 8'h3C with a low stop bit: `frameErr`=1 and nothing is pushed. Then hold `rx` low for 3000 cycles: still only one error and no push. Then `clearErr` sets `frameErr` back to 0.
- Send 5 bytes 8'h01..8'h05 back-to-back with no reads: `overrun`=1 after the fifth. Reads return 01, 02, 03, 04, then `valid`=0.
- With the FIFO full, assert `recvAck` in the exact stop-sample+1 cycle of a sixth byte 8'h06: no overrun, and subsequent reads return 02, 03, 04, 06.
- Assert `resetn` low halfway through the data bits of 8'hFF, release, and leave the line high: `valid`=0, flags 0, and no spurious byte is received. A following 8'h5A is received correctly.
